// File: rtl/frame_scaler.sv
// frame_scaler: walks every destination pixel in raster order and writes it
// once to the frame buffer. Pixels inside the output region are produced from
// the source ROM by copy, 2x replicate, 2x/4x decimation or 2x2/4x4 block
// averaging. All other pixels get BG.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             begin a transfer (sampled only in IDLE)
//   mode[2:0]         transform select, latched on an accepted start
//   busy, done        transfer in progress / one-cycle completion pulse
//   src_addr, src_q   source ROM read port (q valid MEM_LAT cycles after addr)
//   dst_addr, dst_data, dst_wren   frame buffer write port
module frame_scaler #(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int DST_W   = 640,
  parameter int DST_H   = 480,
  parameter int PIX_W   = 8,
  parameter int SRC_AW  = 17,
  parameter int DST_AW  = 19,
  parameter int MEM_LAT = 1,
  parameter logic [PIX_W-1:0] BG = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_q,
  output logic [DST_AW-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_wren
);

  function automatic int clip(input int v, input int lim);
    return (v < lim) ? v : lim;
  endfunction

  localparam int XW     = $clog2(DST_W + 1);
  localparam int YW     = $clog2(DST_H + 1);
  localparam int AW     = PIX_W + 4;
  localparam int STAGES = MEM_LAT - 1;

  // Output region per mode family, clipped to the destination.
  localparam int OW0 = clip(SRC_W,      DST_W);
  localparam int OH0 = clip(SRC_H,      DST_H);
  localparam int OW1 = clip(2 * SRC_W,  DST_W);
  localparam int OH1 = clip(2 * SRC_H,  DST_H);
  localparam int OW2 = clip(SRC_W >> 1, DST_W);
  localparam int OH2 = clip(SRC_H >> 1, DST_H);
  localparam int OW4 = clip(SRC_W >> 2, DST_W);
  localparam int OH4 = clip(SRC_H >> 2, DST_H);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  function automatic logic [2:0] mode_norm(input logic [2:0] m);
    return (m > 3'd5) ? 3'd0 : m;
  endfunction

  function automatic logic [XW-1:0] ow_of(input logic [2:0] m);
    case (m)
      3'd1:       return XW'(OW1);
      3'd2, 3'd3: return XW'(OW2);
      3'd4, 3'd5: return XW'(OW4);
      default:    return XW'(OW0);
    endcase
  endfunction

  function automatic logic [YW-1:0] oh_of(input logic [2:0] m);
    case (m)
      3'd1:       return YW'(OH1);
      3'd2, 3'd3: return YW'(OH2);
      3'd4, 3'd5: return YW'(OH4);
      default:    return YW'(OH0);
    endcase
  endfunction

  // Source column of the first sample for destination column dx.
  function automatic logic [SRC_AW-1:0] sx_of(input logic [2:0] m, input logic [XW-1:0] dx);
    case (m)
      3'd1:       return SRC_AW'(dx >> 1);
      3'd2, 3'd3: return SRC_AW'(dx) << 1;
      3'd4, 3'd5: return SRC_AW'(dx) << 2;
      default:    return SRC_AW'(dx);
    endcase
  endfunction

  // Highest sub-sample offset inside a block (0 = single sample).
  function automatic logic [1:0] smax_of(input logic [2:0] m);
    case (m)
      3'd3:    return 2'd1;
      3'd5:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  state_t              state, state_nxt;
  logic [2:0]          mode_q;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [DST_AW-1:0]   dst_row;   // y*DST_W
  logic [SRC_AW-1:0]   s_row;     // first-sample source row * SRC_W
  logic [SRC_AW-1:0]   samp_row;  // s_row + sj*SRC_W
  logic [1:0]          si, sj;
  logic [AW-1:0]       acc;
  logic [STAGES:0]     vld_pipe;

  logic [2:0]          mode_in;
  logic                first_in;
  logic                x_last, pix_last, in_n, samp_last, wait_last;
  logic [XW-1:0]       x_n;
  logic [YW-1:0]       y_n;
  logic [DST_AW-1:0]   dst_row_n;
  logic [SRC_AW-1:0]   s_row_n, row_step, sx_cur, samp_row_n;
  logic [1:0]          smax, si_n, sj_n;
  logic [AW-1:0]       sum;
  logic [PIX_W-1:0]    result;

  // ---------------- datapath helpers ----------------
  always_comb begin
    mode_in  = mode_norm(mode);
    first_in = (ow_of(mode_in) != '0) && (oh_of(mode_in) != '0);

    x_last   = (x == XW'(DST_W - 1));
    pix_last = x_last && (y == YW'(DST_H - 1));

    // Replicate mode advances the source row only every second line.
    case (mode_q)
      3'd1:       row_step = y[0] ? SRC_AW'(SRC_W) : '0;
      3'd2, 3'd3: row_step = SRC_AW'(2 * SRC_W);
      3'd4, 3'd5: row_step = SRC_AW'(4 * SRC_W);
      default:    row_step = SRC_AW'(SRC_W);
    endcase

    x_n       = x_last ? '0 : x + 1'b1;
    y_n       = x_last ? y + 1'b1 : y;
    dst_row_n = x_last ? dst_row + DST_AW'(DST_W) : dst_row;
    s_row_n   = x_last ? s_row + row_step : s_row;
    in_n      = (x_n < ow_of(mode_q)) && (y_n < oh_of(mode_q));

    smax       = smax_of(mode_q);
    samp_last  = (si == smax) && (sj == smax);
    si_n       = (si == smax) ? 2'd0 : si + 2'd1;
    sj_n       = (si == smax) ? sj + 2'd1 : sj;
    samp_row_n = (si == smax) ? samp_row + SRC_AW'(SRC_W) : samp_row;
    sx_cur     = sx_of(mode_q, x);

    wait_last = vld_pipe[STAGES];
    sum       = acc + AW'(src_q);
    case (mode_q)
      3'd3:    result = PIX_W'(sum >> 2);
      3'd5:    result = PIX_W'(sum >> 4);
      default: result = src_q;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dst_wren  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = first_in ? ISSUE : WRITE;
      ISSUE: begin
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_last) state_nxt = samp_last ? WRITE : ISSUE;
      end
      WRITE: begin
        busy      = 1'b1;
        dst_wren  = 1'b1;
        state_nxt = pix_last ? DONE : (in_n ? ISSUE : WRITE);
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  // src_addr is loaded on the edge entering ISSUE and held through WAIT.
  // dst_addr/dst_data are loaded on the edge entering WRITE, so they move
  // only together with the write strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= '0;
      x        <= '0;
      y        <= '0;
      dst_row  <= '0;
      s_row    <= '0;
      samp_row <= '0;
      si       <= '0;
      sj       <= '0;
      acc      <= '0;
      vld_pipe <= '0;
      src_addr <= '0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      // One bit per WAIT cycle after ISSUE; the top bit marks the last one.
      vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(state == ISSUE);
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode_in;
          x        <= '0;
          y        <= '0;
          dst_row  <= '0;
          s_row    <= '0;
          samp_row <= '0;
          si       <= '0;
          sj       <= '0;
          acc      <= '0;
          if (first_in) src_addr <= '0;
          else begin
            dst_addr <= '0;
            dst_data <= BG;
          end
        end
        WAIT: if (wait_last) begin
          if (!samp_last) begin
            acc      <= sum;
            si       <= si_n;
            sj       <= sj_n;
            samp_row <= samp_row_n;
            src_addr <= samp_row_n + sx_cur + SRC_AW'(si_n);
          end else begin
            acc      <= '0;
            dst_addr <= dst_row + DST_AW'(x);
            dst_data <= result;
          end
        end
        WRITE: if (!pix_last) begin
          x        <= x_n;
          y        <= y_n;
          dst_row  <= dst_row_n;
          s_row    <= s_row_n;
          samp_row <= s_row_n;
          si       <= '0;
          sj       <= '0;
          if (in_n) src_addr <= s_row_n + sx_of(mode_q, x_n);
          else begin
            dst_addr <= dst_row_n + DST_AW'(x_n);
            dst_data <= BG;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
